// File: rtl/basic_mux_pkg.sv
// Shared types and widths for the project mux and its control block.
package basic_mux_pkg;

    localparam int unsigned MUX_ADDR_W = 5;
    localparam int unsigned MUX_IW_W   = 18;
    localparam int unsigned MUX_OW_W   = 24;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SETTLE = 2'd1,
        ON     = 2'd2
    } mux_ctrl_state_t;

endpackage

// File: rtl/basic_mux_ctrl_sync_ff.sv
// Single-bit multi-flop synchroniser for slow asynchronous pin inputs.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/basic_mux_ctrl.sv
// Mux address/enable controller: synchronised increment counter with
// break-before-make enable sequencing.
module basic_mux_ctrl
    import basic_mux_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS  = 24,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel_inc_in,
    input  logic                  sel_rst_in,
    input  logic                  ena_in,
    output logic [MUX_ADDR_W-1:0] addr,
    output logic                  ena,
    output logic                  settling,
    output logic                  addr_valid
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    logic inc_s;
    logic rst_s;
    logic en_s;
    logic inc_prev;
    logic inc_evt;
    logic inc_pend;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    mux_ctrl_state_t  state;
    mux_ctrl_state_t  state_next;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_inc (
        .clk (clk),
        .rst (rst),
        .d   (sel_inc_in),
        .q   (inc_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk (clk),
        .rst (rst),
        .d   (sel_rst_in),
        .q   (rst_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk (clk),
        .rst (rst),
        .d   (ena_in),
        .q   (en_s)
    );

    assign inc_evt    = inc_s && !inc_prev;
    assign addr_valid = (32'(addr) < NUM_PROJECTS);

    // Next-state and settle counter; an increment always routes through SETTLE
    // so ena is low before the address moves.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            OFF: begin
                if (en_s && !rst_s && addr_valid && !inc_pend) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_LOAD;
                end
            end
            SETTLE: begin
                if (!en_s || rst_s || !addr_valid) begin
                    state_next = OFF;
                end else if (inc_evt || inc_pend) begin
                    cnt_next = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_next = ON;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ON: begin
                if (!en_s || rst_s) begin
                    state_next = OFF;
                end else if (inc_evt) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_LOAD;
                end
            end
            default: begin
                state_next = OFF;
            end
        endcase
        if (rst_s) begin
            state_next = OFF;
        end
    end

    // State, counter, address and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            cnt      <= '0;
            ena      <= 1'b0;
            settling <= 1'b0;
            inc_prev <= 1'b0;
            inc_pend <= 1'b0;
            addr     <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ena      <= (state_next == ON);
            settling <= (state_next == SETTLE);
            inc_prev <= inc_s;
            if (rst_s) begin
                addr     <= '0;
                inc_pend <= 1'b0;
            end else begin
                if (inc_pend) begin
                    addr <= addr + MUX_ADDR_W'(1);
                end
                inc_pend <= inc_evt;
            end
        end
    end

endmodule

// File: tb/tb_basic_mux_ctrl.sv
// Directed bench for basic_mux_ctrl with hand-computed cycle timing.
module tb_basic_mux_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_inc_in;
    logic       sel_rst_in;
    logic       ena_in;
    logic [4:0] addr;
    logic       ena;
    logic       settling;
    logic       addr_valid;

    int total = 0;
    int bad   = 0;

    basic_mux_ctrl #(
        .NUM_PROJECTS  (24),
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel_inc_in (sel_inc_in),
        .sel_rst_in (sel_rst_in),
        .ena_in     (ena_in),
        .addr       (addr),
        .ena        (ena),
        .settling   (settling),
        .addr_valid (addr_valid)
    );

    always #5 clk = ~clk;

    // Advance n active edges; inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle pulse; returns four edges later, right after the address step.
    task automatic pulse();
        sel_inc_in = 1'b1;
        step(1);
        sel_inc_in = 1'b0;
        step(3);
    endtask

    // Increment from ON: ena drops one edge before addr steps, returns 4 edges after the step.
    task automatic inc_from_on(input logic [4:0] a);
        sel_inc_in = 1'b1;
        step(1);
        sel_inc_in = 1'b0;
        step(1);
        chk("inc_pre_ena", 32'(ena), 32'd1);
        step(1);
        chk("inc_e_ena", 32'(ena), 32'd0);
        chk("inc_e_addr", 32'(addr), 32'(a));
        step(1);
        chk("inc_e1_addr", 32'(addr), 32'(a + 5'd1));
        chk("inc_e1_ena", 32'(ena), 32'd0);
        step(3);
        chk("inc_settle_ena", 32'(ena), 32'd0);
        step(1);
        chk("inc_on_ena", 32'(ena), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        sel_inc_in = 1'b0;
        sel_rst_in = 1'b0;
        ena_in     = 1'b1;
        step(2);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_settling", 32'(settling), 32'd0);
        chk("rst_valid", 32'(addr_valid), 32'd1);

        // Reset release: two sync edges, one to enter SETTLE, four settle cycles.
        rst = 1'b0;
        step(2);
        chk("rel_sync_settling", 32'(settling), 32'd0);
        step(1);
        chk("rel_settle_in", 32'(settling), 32'd1);
        chk("rel_settle_in_ena", 32'(ena), 32'd0);
        step(3);
        chk("rel_settle_last", 32'(settling), 32'd1);
        chk("rel_settle_last_ena", 32'(ena), 32'd0);
        step(1);
        chk("rel_on_ena", 32'(ena), 32'd1);
        chk("rel_on_settling", 32'(settling), 32'd0);

        // Three separated increments 0->1->2->3.
        for (int i = 0; i < 3; i++) inc_from_on(5'(i));
        chk("three_inc_addr", 32'(addr), 32'd3);

        // Second pulse lands mid-SETTLE and reloads the counter.
        pulse();
        chk("reload_first_addr", 32'(addr), 32'd4);
        sel_inc_in = 1'b1;
        step(1);
        sel_inc_in = 1'b0;
        step(2);
        chk("reload_evt_settling", 32'(settling), 32'd1);
        step(1);
        chk("reload_second_addr", 32'(addr), 32'd5);
        chk("reload_second_ena", 32'(ena), 32'd0);
        step(3);
        chk("reload_hold_ena", 32'(ena), 32'd0);
        step(1);
        chk("reload_on_ena", 32'(ena), 32'd1);
        chk("reload_on_addr", 32'(addr), 32'd5);

        // One-cycle global reset while ON at addr 5.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("grst_addr", 32'(addr), 32'd0);
        chk("grst_ena", 32'(ena), 32'd0);
        chk("grst_settling", 32'(settling), 32'd0);
        step(6);
        chk("grst_resync_ena", 32'(ena), 32'd0);
        step(1);
        chk("grst_on_ena", 32'(ena), 32'd1);

        // Walk to addr 7 and wait for ena.
        for (int i = 0; i < 7; i++) pulse();
        chk("walk7_addr", 32'(addr), 32'd7);
        step(3);
        chk("walk7_pre_ena", 32'(ena), 32'd0);
        step(1);
        chk("walk7_ena", 32'(ena), 32'd1);

        // Select-reset: addr and ena clear on the same edge once synchronised.
        sel_rst_in = 1'b1;
        step(2);
        chk("srst_sync_addr", 32'(addr), 32'd7);
        chk("srst_sync_ena", 32'(ena), 32'd1);
        step(1);
        chk("srst_addr", 32'(addr), 32'd0);
        chk("srst_ena", 32'(ena), 32'd0);
        pulse();
        pulse();
        chk("srst_pulse_addr", 32'(addr), 32'd0);
        chk("srst_pulse_ena", 32'(ena), 32'd0);
        sel_rst_in = 1'b0;
        step(6);
        chk("srst_rel_ena", 32'(ena), 32'd0);
        step(1);
        chk("srst_rel_on", 32'(ena), 32'd1);
        chk("srst_rel_addr", 32'(addr), 32'd0);

        // Past the populated slots, then wrap back to 0.
        for (int i = 0; i < 23; i++) pulse();
        chk("a23_addr", 32'(addr), 32'd23);
        chk("a23_valid", 32'(addr_valid), 32'd1);
        pulse();
        chk("a24_addr", 32'(addr), 32'd24);
        chk("a24_valid", 32'(addr_valid), 32'd0);
        step(6);
        chk("a24_ena", 32'(ena), 32'd0);
        chk("a24_settling", 32'(settling), 32'd0);
        for (int i = 0; i < 7; i++) pulse();
        chk("a31_addr", 32'(addr), 32'd31);
        chk("a31_ena", 32'(ena), 32'd0);
        pulse();
        chk("wrap_addr", 32'(addr), 32'd0);
        chk("wrap_valid", 32'(addr_valid), 32'd1);
        chk("wrap_ena", 32'(ena), 32'd0);
        step(1);
        chk("wrap_settling", 32'(settling), 32'd1);
        step(3);
        chk("wrap_pre_ena", 32'(ena), 32'd0);
        step(1);
        chk("wrap_on_ena", 32'(ena), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
